// File: rtl/falling_expr_pkg.sv
// Shared types and helpers for the falling-expression game core.
// Expression and answer widths, op codes, FSM state type, insertion-time evaluator.
// Expression format: {a[3:0], op[3:0], b[3:0]}; a zero word marks an empty slot.
package falling_expr_pkg;

    localparam int EXP_W = 12;
    localparam int ANS_W = 8;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_e;

    typedef struct packed {
        logic             vld;
        logic [ANS_W-1:0] ans;
    } eval_t;

    // Answer modulo 256; vld=0 for an op code that is not an operator.
    function automatic eval_t eval_expr(input logic [EXP_W-1:0] exp);
        logic [3:0] a;
        logic [3:0] op;
        logic [3:0] b;
        eval_t      res;
        a       = exp[11:8];
        op      = exp[7:4];
        b       = exp[3:0];
        res.vld = 1'b1;
        res.ans = '0;
        case (op)
            OP_ADD:  res.ans = {4'h0, a} + {4'h0, b};
            OP_SUB:  res.ans = {4'h0, a} - {4'h0, b};
            OP_MUL:  res.ans = {4'h0, a} * {4'h0, b};
            OP_DIV:  res.ans = (b == 4'h0) ? 8'hFF : {4'h0, a / b};
            default: res.vld = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/falling_expr_lane.sv
// One lane of the grid: DEPTH expression/answer registers, lowest-slot match, shift and insert.
// Latency: state updates on the next clk edge; match_o and bot_occ_o are combinational.
// No backpressure: adv_i and chk_i are acted on whenever asserted.
// Ports: adv_i shifts the lane down one row, inserting ins_exp_i/ins_ans_i at row 0 when ins_i;
// chk_i compares ans_i with the lowest occupied slot and clears it on match (match_o);
// bot_occ_o flags the bottom row still occupied after that clearing; slot_o is row r at [r*EXP_W +: EXP_W].
module falling_expr_lane
    import falling_expr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv_i,
    input  logic                   chk_i,
    input  logic [ANS_W-1:0]       ans_i,
    input  logic                   ins_i,
    input  logic [EXP_W-1:0]       ins_exp_i,
    input  logic [ANS_W-1:0]       ins_ans_i,
    output logic                   match_o,
    output logic                   bot_occ_o,
    output logic [DEPTH*EXP_W-1:0] slot_o
);

    logic [EXP_W-1:0] exp_q [DEPTH];
    logic [EXP_W-1:0] exp_c [DEPTH];
    logic [EXP_W-1:0] exp_d [DEPTH];
    logic [ANS_W-1:0] ans_q [DEPTH];
    logic [ANS_W-1:0] ans_c [DEPTH];
    logic [ANS_W-1:0] ans_d [DEPTH];
    logic             found;

    always_comb begin
        exp_c   = exp_q;
        ans_c   = ans_q;
        match_o = 1'b0;
        found   = 1'b0;
        // Scan bottom-up; only the first occupied slot is a candidate for the answer.
        for (int r = DEPTH - 1; r >= 0; r--) begin
            if (!found && exp_q[r] != '0) begin
                found = 1'b1;
                if (chk_i && ans_q[r] == ans_i) begin
                    match_o  = 1'b1;
                    exp_c[r] = '0;
                    ans_c[r] = '0;
                end
            end
        end
        // Evaluated after clearing so a slot answered on the tick cycle is never an overflow.
        bot_occ_o = (exp_c[DEPTH-1] != '0);
        exp_d     = exp_c;
        ans_d     = ans_c;
        if (adv_i) begin
            for (int r = DEPTH - 1; r > 0; r--) begin
                exp_d[r] = exp_c[r-1];
                ans_d[r] = ans_c[r-1];
            end
            exp_d[0] = ins_i ? ins_exp_i : '0;
            ans_d[0] = ins_i ? ins_ans_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                exp_q[r] <= '0;
                ans_q[r] <= '0;
            end
        end else begin
            exp_q <= exp_d;
            ans_q <= ans_d;
        end
    end

    always_comb begin
        slot_o = '0;
        for (int r = 0; r < DEPTH; r++) begin
            slot_o[r*EXP_W +: EXP_W] = exp_q[r];
        end
    end

endmodule

// File: rtl/falling_expr_core.sv
// Falling arithmetic-expression game core: LANES x DEPTH grid, answer matching, score/life/combo.
// Latency: all outputs registered, 1 cycle after tick/ans_valid; game_over 1 cycle after life hits 0.
// No backpressure: tick and ans_valid accepted every cycle in RUN, ignored in OVER.
// Ports: tick/new_exp/new_lane insert and advance; ans_valid/ans_in answer attempts;
// slot_exp grid (slot (l,r) at [(l*DEPTH+r)*12 +: 12]); score, life, combo, hit, game_over.
// Option MISS_PENALTY_EN: an answer attempt with no hit clears combo.
module falling_expr_core
    import falling_expr_pkg::*;
#(
    parameter int LANES     = 3,
    parameter int DEPTH     = 2,
    parameter int SCORE_W   = 7,
    parameter int LIFE_INIT = 3,
    parameter int LIFE_MAX  = 5,
    parameter int COMBO_MAX = 15,
    localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [EXP_W-1:0]             new_exp,
    input  logic [LW-1:0]                new_lane,
    input  logic                         ans_valid,
    input  logic [ANS_W-1:0]             ans_in,
    output logic [LANES*DEPTH*EXP_W-1:0] slot_exp,
    output logic [SCORE_W-1:0]           score,
    output logic [2:0]                   life,
    output logic [3:0]                   combo,
    output logic                         hit,
    output logic                         game_over
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         life_q, life_d;
    logic [3:0]         combo_q, combo_d;
    logic               hit_q, hit_d;

    logic               run, adv, chk;
    logic               any_hit, loss, bonus;
    logic [LANES-1:0]   match, bot_occ;
    eval_t              new_eval;
    logic               lane_ok;

    assign run      = (state_q == RUN);
    assign adv      = tick & run;
    assign chk      = ans_valid & run;
    assign new_eval = eval_expr(new_exp);
    assign lane_ok  = (int'(new_lane) < LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        falling_expr_lane #(
            .DEPTH(DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .adv_i     (adv),
            .chk_i     (chk),
            .ans_i     (ans_in),
            .ins_i     (adv && new_eval.vld && lane_ok && (new_lane == LW'(l))),
            .ins_exp_i (new_exp),
            .ins_ans_i (new_eval.ans),
            .match_o   (match[l]),
            .bot_occ_o (bot_occ[l]),
            .slot_o    (slot_exp[l*DEPTH*EXP_W +: DEPTH*EXP_W])
        );
    end

    always_comb begin
        any_hit = |match;
        loss    = adv && (|bot_occ);
        bonus   = any_hit && (combo_q == 4'(COMBO_MAX));

        // One point per matching lane, saturating.
        score_d = score_q;
        for (int l = 0; l < LANES; l++) begin
            if (match[l] && score_d != '1) begin
                score_d = score_d + 1'b1;
            end
        end

        // Bonus and overflow on the same cycle cancel, even at LIFE_MAX.
        life_d = life_q;
        if (bonus && loss) begin
            life_d = life_q;
        end else if (bonus) begin
            if (life_q < 3'(LIFE_MAX)) begin
                life_d = life_q + 3'd1;
            end
        end else if (loss && life_q != 3'd0) begin
            life_d = life_q - 3'd1;
        end

        combo_d = combo_q;
        if (any_hit) begin
            combo_d = bonus ? 4'd0 : combo_q + 4'd1;
        end
`ifdef MISS_PENALTY_EN
        else if (chk) begin
            combo_d = 4'd0;
        end
`else
`endif
        if (loss) begin
            combo_d = 4'd0;
        end

        hit_d   = run ? any_hit : hit_q;
        state_d = (run && life_q == 3'd0) ? OVER : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            score_q <= '0;
            life_q  <= 3'(LIFE_INIT);
            combo_q <= 4'd0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            life_q  <= life_d;
            combo_q <= combo_d;
            hit_q   <= hit_d;
        end
    end

    assign score     = score_q;
    assign life      = life_q;
    assign combo     = combo_q;
    assign hit       = hit_q;
    assign game_over = (state_q == OVER);

endmodule

// File: doc/falling_expr_core.md
# falling_expr_core

Parametrised successor to the three-lane math-game core. It holds a LANES × DEPTH grid of falling arithmetic expressions, each stored with an answer precomputed at insertion. It checks keypad answers against the lowest expression in every lane and keeps score, life and combo. It sits between the expression generator (tick and new expression) and the LCD/keypad front ends, which consume the slot grid and the counters.

## Interface
- LANES, 3: number of columns.
- DEPTH, 2: rows per lane; row 0 is the top, row DEPTH-1 the bottom.
- SCORE_W, 7: score width; the score saturates at 2^SCORE_W-1.
- LIFE_INIT, 3: life value after reset.
- LIFE_MAX, 5: upper bound on life; the life port is 3 bits.
- COMBO_MAX, 15: combo value at which the next hit grants a bonus life.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous and active-high.
- tick  in  1  one-cycle pulse that advances every lane one row.
- new_exp  in  12  expression to insert on tick: {a[3:0], op[3:0], b[3:0]}. 0 means no insert.
- new_lane  in  $clog2(LANES)  target lane for new_exp.
- ans_valid  in  1  one-cycle pulse; ans_in is valid.
- ans_in  in  8  player answer.
- slot_exp  out  LANES*DEPTH*12  grid contents; slot (l,r) sits at bits [(l*DEPTH+r)*12 +: 12].
- score  out  SCORE_W  score.
- life  out  3  remaining lives.
- combo  out  4  consecutive-hit counter.
- hit  out  1  one-cycle pulse: at least one slot was cleared by an answer.
- game_over  out  1  high while in state OVER.

## Operation
- States are RUN and OVER. RUN moves to OVER when the registered life value becomes 0. OVER leaves only on rst.
- In OVER, tick and ans_valid are ignored and all outputs hold.
- Reset values:
  - slot_exp and all stored answers: 0.
  - score: 0.
  - life: LIFE_INIT.
  - combo: 0.
  - hit: 0.
  - game_over: 0.
  - State: RUN.
- Answer evaluation at insertion, computed modulo 256:
  - op 0xA: a+b.
  - op 0xB: a-b, two's-complement wrap, so 3-5 gives 0xFE.
  - op 0xC: a*b.
  - op 0xD: a/b, truncating. b=0 gives 0xFF.
  - Any other op code: no insert.
- An insert is also dropped when new_lane ≥ LANES.
- Answer check, done per lane when ans_valid=1 in RUN:
  - The target is the occupied slot with the highest row index.
  - If its stored answer equals ans_in, that slot is cleared.
  - Lanes are independent: k matching lanes add k to the score (saturating) and clear k slots.
- Combo on any cycle with at least one hit:
  - If combo = COMBO_MAX: combo becomes 0 and life increments, up to LIFE_MAX.
  - Otherwise combo increments by 1, regardless of how many lanes hit.
- Tick sequence in RUN:
  - If any bottom-row slot is still occupied after this cycle's answer clearing, life decrements by 1 (once per tick, however many slots overflow) and combo becomes 0.
  - Every lane then shifts down one row and the bottom row is discarded.
  - Row 0 of new_lane receives new_exp with its answer; all other row-0 slots become 0.
- Simultaneous tick and ans_valid: the answer is checked against the pre-shift grid first. A slot cleared this way cannot cost a life.
- Simultaneous combo bonus and tick loss: the net life change is 0.
- life never wraps: the decrement stops at 0.

## Timing
- All outputs are registered.
- slot_exp, score, life, combo and hit update on the clock edge that samples tick or ans_valid (1-cycle latency).
- game_over rises one cycle after life becomes 0.
- ans_valid held high for several cycles is treated as repeated attempts. A second attempt targets the next occupied slot in each lane.
- There is no backpressure. tick and ans_valid are accepted on every cycle.
- rst asserted mid-game restores reset values on the next edge and overrides tick and ans_valid.

## Configuration
- MISS_PENALTY_EN defined: an ans_valid with zero hits (in RUN) sets combo to 0 on the next edge.
- MISS_PENALTY_EN undefined: a wrong answer has no effect on any state. This is the legacy behaviour.

## Structure
- Package falling_expr_pkg holds:
  - EXP_W=12 and ANS_W=8.
  - Op-code constants OP_ADD=4'hA, OP_SUB=4'hB, OP_MUL=4'hC, OP_DIV=4'hD.
  - The state enum {RUN, OVER}.
  - Function eval_expr(exp) that returns the 8-bit answer and a valid flag.
- Sub-module falling_expr_lane, one instance per lane:
  - Holds the DEPTH expression and answer registers.
  - Implements shift, insert and lowest-slot match.
  - Outputs a match flag and a bottom-occupied flag.
- The top level holds the FSM, the counters, and the per-lane generate loop.

## Test plan
- Reset, then tick with new_exp=0x3A4 on lane 1 → slot(1,0)=0x3A4. ans_in=7 with ans_valid → slot cleared, score=1, combo=1, hit pulses.
- Two ticks with no answer after inserting 0x2C3 on lane 0 (DEPTH=2) → the second tick costs a life: life=2, combo=0, and lane 0 is empty.
- Insert 0x5D0 and answer 0xFF → hit. Insert 0x3B5 and answer 0xFE → hit. Op 0x7 → nothing inserted.
- 15 consecutive hits, then a 16th with life=5 → combo goes 15→0 and life stays 5. Repeat with life=3 → life=4.
- Lanes 0 and 2 both hold answer 9; ans_in=9 arrives in the same cycle as a tick with both in the bottom row → score +2, no life lost, both lanes shift.
- life=1 and an unanswered bottom slot on tick → life=0 and game_over=1 on the next cycle. Later ticks and answers are ignored; rst → life=3 and game_over=0.
